fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//   Read-side consumer of the async FIFO, in the FIFO read-clock domain.
//   Drains bytes through the FIFO's rd_en/empty/rdata handshake.
//   Packs NUM_BYTES bytes little-endian into one word.
//   Presents the word downstream on a valid/ready stream.
// PARAMETERS
//   WIDTH      8   FIFO data width, bits per lane
//   NUM_BYTES  4   lanes per output word; power of 2, >= 2
//   TIMEOUT    16  idle cycles before a partial word is flushed (PACK_TIMEOUT_EN only); >= 1
// PORTS
//   clk_i       in   1                single clock = FIFO rd_clk_i
//   rst_n_i     in   1                asynchronous, active-low reset
//   empty_i     in   1                FIFO empty_o
//   rdata_i     in   WIDTH            FIFO rdata_o; valid 1 cycle after rd_en_o
//   rd_en_o     out  1                FIFO rd_en_i
//   m_data_o    out  WIDTH*NUM_BYTES  packed word; lane k = bits [k*WIDTH +: WIDTH]
//   m_keep_o    out  NUM_BYTES        lane-valid mask
//   m_valid_o   out  1                word valid
//   m_ready_i   in   1                downstream accepts
//   words_o     out  16               count of accepted words; wraps at 0xFFFF
// BEHAVIOUR
//   Reset values: rd_en_o=0, m_data_o=0, m_keep_o=0, m_valid_o=0, words_o=0.
//     FSM=FILL, lane count cnt=0, inflight=0, timer=0.
//   Reset mid-operation discards partially packed bytes and any in-flight byte.
//   FSM has two states, FILL and HOLD.
//   FILL
//     - Comb: rd_en_o = !empty_i && (cnt + inflight < NUM_BYTES).
//     - rd_en_o is never 1 while empty_i=1, so the FIFO never sees a read error.
//     - inflight <= rd_en_o.
//     - If inflight=1: lane[cnt] <= rdata_i, cnt <= cnt+1.
//     - Back-to-back reads give 1 byte/cycle.
//     - On the capture that fills lane NUM_BYTES-1, go to HOLD next cycle:
//       m_valid_o=1, m_keep_o=all ones, cnt=0.
//   HOLD
//     - rd_en_o=0.
//     - m_data_o and m_keep_o are held stable while m_valid_o && !m_ready_i.
//     - On m_valid_o && m_ready_i:
//       m_valid_o<=0, m_data_o<=0, m_keep_o<=0, words_o<=words_o+1, FSM<=FILL.
//     - Reads resume the cycle after acceptance.
//     - The minimum gap between words is 1 cycle.
//   m_ready_i is ignored while m_valid_o=0; there is no combinational ready->valid path.
//   Empty asserting mid-word stalls packing with no data loss.
//     Lanes already captured are kept.
// CONFIGURATION
//   PACK_TIMEOUT_EN defined
//     - In FILL with 0 < cnt < NUM_BYTES and inflight=0, timer increments
//       each cycle that rd_en_o=0.
//     - The timer clears on any capture.
//     - When timer reaches TIMEOUT:
//       - go to HOLD with m_keep_o[k]=1 for k<cnt;
//       - unfilled lanes are 0;
//       - cnt=0, timer=0.
//   PACK_TIMEOUT_EN undefined
//     - No timer; partial words wait indefinitely.
//     - m_keep_o is all ones whenever m_valid_o=1.
// TESTING
//   1. Push 11,22,33,44, m_ready_i=1
//      -> m_data_o=0x44332211, m_keep_o=0xF, one-cycle valid, words_o=1.
//   2. Push 8 bytes 01..08, m_ready_i=0 for 5 cycles, then 1
//      -> 0x04030201 held stable 5 cycles, no rd_en_o in HOLD.
//      -> Then 0x08070605; words_o=2.
//   3. FIFO empty for 50 cycles
//      -> rd_en_o stays 0, m_valid_o stays 0; FIFO rd_error never set.
//   4. [PACK_TIMEOUT_EN] push AA,BB, then idle
//      -> 16 cycles after the last capture: m_data_o=0x0000BBAA, m_keep_o=0x3.
//      -> Without the macro, m_valid_o stays 0 for 100 cycles.
//   5. Push 3 bytes, pulse rst_n_i low mid-word, then push 4 more (C1..C4)
//      -> all outputs 0 during reset.
//      -> First word after reset is 0xC4C3C2C1, keep 0xF.
//   6. Push 400 random bytes with random m_ready_i
//      -> 100 words; the scoreboard matches byte order; words_o=100.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer of an async FIFO, running in the FIFO read-clock domain.
//   Bytes are drained through the FIFO rd_en/empty/rdata handshake (rdata valid
//   one cycle after rd_en). NUM_BYTES bytes are packed little-endian into one
//   word, which is then offered downstream on a valid/ready stream.
//
//   Optional feature: define PACK_TIMEOUT_EN to flush a partially packed word
//   after TIMEOUT idle cycles. With the macro undefined, partial words wait
//   indefinitely and m_keep_o is all ones whenever m_valid_o is high.
//
// Ports
//   clk_i      single clock (FIFO read clock)
//   rst_n_i    asynchronous active-low reset
//   empty_i    FIFO empty flag
//   rdata_i    FIFO read data, valid the cycle after rd_en_o
//   rd_en_o    FIFO read enable (never asserted while empty_i is high)
//   m_data_o   packed word, lane k = bits [k*WIDTH +: WIDTH]
//   m_keep_o   lane-valid mask
//   m_valid_o  word valid
//   m_ready_i  downstream accepts (ignored while m_valid_o is low)
//   words_o    count of accepted words, wraps at 0xFFFF

module fifo_rd_packer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_BYTES = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       empty_i,
    input  logic [WIDTH-1:0]           rdata_i,
    output logic                       rd_en_o,
    output logic [WIDTH*NUM_BYTES-1:0] m_data_o,
    output logic [NUM_BYTES-1:0]       m_keep_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [15:0]                words_o
);

    // Lane counter only ever holds 0..NUM_BYTES-1; it wraps to 0 on the final capture.
    localparam int unsigned     CW       = $clog2(NUM_BYTES);
    localparam logic [CW:0]     Full     = (CW+1)'(NUM_BYTES);
    localparam logic [CW-1:0]   LastLane = CW'(NUM_BYTES - 1);

    localparam logic [0:0] StFill = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       inflight_q, inflight_d;
    logic [WIDTH*NUM_BYTES-1:0] data_q, data_d;
    logic [NUM_BYTES-1:0]       keep_q, keep_d;
    logic                       valid_q, valid_d;
    logic [15:0]                words_q, words_d;

    logic [CW:0] occ;
    logic        rd_en;
    logic        capture;

    // Lanes already captured plus the byte still on its way from the FIFO.
    assign occ     = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
    // Gated by reset so no read is issued while the block is held in reset.
    assign rd_en   = rst_n_i && (state_q == StFill) && !empty_i && (occ < Full);
    assign capture = (state_q == StFill) && inflight_q;

`ifdef PACK_TIMEOUT_EN
    localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

    logic [TW-1:0] timer_q, timer_d;
    logic          timer_run;
    logic          timer_fire;

    // Only count while a partial word sits idle with nothing requested or in flight.
    assign timer_run  = (state_q == StFill) && (cnt_q != '0) && !inflight_q && !rd_en;
    assign timer_fire = timer_run && ((timer_q + TW'(1)) == TimeoutVal);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inflight_d = rd_en;
        data_d     = data_q;
        keep_d     = keep_q;
        valid_d    = valid_q;
        words_d    = words_q;
`ifdef PACK_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            StFill: begin
                if (capture) begin
                    for (int k = 0; k < int'(NUM_BYTES); k++) begin
                        if (cnt_q == CW'(k)) begin
                            data_d[k*WIDTH +: WIDTH] = rdata_i;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
`ifdef PACK_TIMEOUT_EN
                    timer_d = '0;
`endif
                    if (cnt_q == LastLane) begin
                        state_d = StHold;
                        valid_d = 1'b1;
                        keep_d  = '1;
                        cnt_d   = '0;
                    end
                end
`ifdef PACK_TIMEOUT_EN
                else if (timer_run) begin
                    if (timer_fire) begin
                        // Flush the partial word; unfilled lanes are already zero.
                        state_d = StHold;
                        valid_d = 1'b1;
                        for (int k = 0; k < int'(NUM_BYTES); k++) begin
                            keep_d[k] = (CW'(k) < cnt_q);
                        end
                        cnt_d   = '0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
`endif
            end
            StHold: begin
                if (valid_q && m_ready_i) begin
                    valid_d = 1'b0;
                    data_d  = '0;
                    keep_d  = '0;
                    words_d = words_q + 16'd1;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            valid_q    <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            valid_q    <= valid_d;
            words_q    <= words_d;
        end
    end

`ifdef PACK_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign rd_en_o   = rd_en;
    assign m_data_o  = data_q;
    assign m_keep_o  = keep_q;
    assign m_valid_o = valid_q;
    assign words_o   = words_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a queue-based FIFO model feeds the DUT, the
// stimulus pushes expected words into a scoreboard and a negedge monitor pops
// and compares every accepted word.

`timescale 1ns/1ps

module tb_fifo_rd_packer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        empty_i;
    logic [7:0]  rdata_i;
    logic        rd_en_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_keep_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [15:0] words_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  fifo_q[$];
    logic [31:0] exp_data_q[$];
    logic [3:0]  exp_keep_q[$];
    logic [31:0] acc_word = '0;
    int          acc_n = 0;

    logic        prev_hold = 1'b0;
    logic        prev_acc  = 1'b0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_keep = '0;

    always #5 clk_i = ~clk_i;

    fifo_rd_packer #(
        .WIDTH    (8),
        .NUM_BYTES(4),
        .TIMEOUT  (16)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .empty_i  (empty_i),
        .rdata_i  (rdata_i),
        .rd_en_o  (rd_en_o),
        .m_data_o (m_data_o),
        .m_keep_o (m_keep_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .words_o  (words_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // FIFO model: rdata follows rd_en by one cycle, empty settles mid-cycle.
    initial begin
        empty_i = 1'b1;
        rdata_i = '0;
        forever begin
            @(posedge clk_i);
            if (rd_en_o && fifo_q.size() > 0) rdata_i <= fifo_q.pop_front();
            #2;
            empty_i = (fifo_q.size() == 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [31:0] ed;
        logic [3:0]  ek;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                prev_hold = 1'b0;
                prev_acc  = 1'b0;
            end else begin
                if (rd_en_o) check("rd_while_empty", 32'(empty_i), 32'd0);
                if (prev_hold) begin
                    check("hold_valid", 32'(m_valid_o), 32'd1);
                    check("hold_data", m_data_o, prev_data);
                    check("hold_keep", 32'(m_keep_o), 32'(prev_keep));
                end
                if (prev_acc) check("gap_after_accept", 32'(m_valid_o), 32'd0);
                if (m_valid_o) check("rd_en_in_hold", 32'(rd_en_o), 32'd0);
                if (m_valid_o && m_ready_i) begin
                    if (exp_data_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got 0x%08h expected none", m_data_o);
                    end else begin
                        ed = exp_data_q.pop_front();
                        ek = exp_keep_q.pop_front();
                        check("word_data", m_data_o, ed);
                        check("word_keep", 32'(m_keep_o), 32'(ek));
                    end
                end
                prev_hold = m_valid_o && !m_ready_i;
                prev_acc  = m_valid_o && m_ready_i;
                prev_data = m_data_o;
                prev_keep = m_keep_o;
            end
        end
    end

    // Push a byte to the FIFO and to the little-endian word accumulator.
    task automatic sb_push(input logic [7:0] b);
        fifo_q.push_back(b);
        acc_word[acc_n*8 +: 8] = b;
        acc_n++;
        if (acc_n == 4) begin
            exp_data_q.push_back(acc_word);
            exp_keep_q.push_back(4'hF);
            acc_n = 0;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk_i);
        #1;
        sb_push(b);
    endtask

    // FIFO only; expected words for these bytes are handled by the caller.
    task automatic fifo_push(input logic [7:0] b);
        @(posedge clk_i);
        #1;
        fifo_q.push_back(b);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk_i);
            if (exp_data_q.size() == 0 && fifo_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got %0d words pending expected 0", name, exp_data_q.size());
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en_o), 32'd0);
        check({tag, "_data"}, m_data_o, 32'd0);
        check({tag, "_keep"}, 32'(m_keep_o), 32'd0);
        check({tag, "_valid"}, 32'(m_valid_o), 32'd0);
        check({tag, "_words"}, 32'(words_o), 32'd0);
    endtask

    initial begin
        int bad;
        int first;
        int idx;
        bit seen;

        rst_n_i   = 1'b0;
        m_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_zero("reset");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // 1: single word, ready high
        m_ready_i = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        wait_drain("t1_drain", 100);
        check("t1_words", 32'(words_o), 32'd1);

        // 2: two words with downstream stall on the first
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            if (m_valid_o) seen = 1'b1;
        end
        check("t2_valid_seen", 32'(seen), 32'd1);
        check("t2_first_data", m_data_o, 32'h0403_0201);
        repeat (4) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b1;
        wait_drain("t2_drain", 100);
        check("t2_words", 32'(words_o), 32'd3);

        // 3: FIFO empty for 50 cycles
        bad = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (rd_en_o || m_valid_o) bad++;
        end
        check("t3_idle", 32'(bad), 32'd0);

        // 4: partial word
`ifdef PACK_TIMEOUT_EN
        fifo_push(8'hAA);
        fifo_push(8'hBB);
        exp_data_q.push_back(32'h0000_BBAA);
        exp_keep_q.push_back(4'h3);
        // BB is captured two edges after its push, then TIMEOUT=16 idle edges.
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (m_valid_o && first == 0) first = k;
        end
        check("t4_flush_cycle", 32'(first), 32'd19);
        wait_drain("t4_drain", 100);
        check("t4_words", 32'(words_o), 32'd4);
`else
        fifo_push(8'hAA);
        fifo_push(8'hBB);
        bad = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (m_valid_o) bad++;
        end
        check("t4_no_flush", 32'(bad), 32'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
`endif

        // 5: reset mid-word discards captured bytes
        fifo_push(8'hD1);
        fifo_push(8'hD2);
        fifo_push(8'hD3);
        repeat (6) @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        sb_push(8'hC1);
        sb_push(8'hC2);
        sb_push(8'hC3);
        sb_push(8'hC4);
        @(negedge clk_i);
        check_zero("t5_reset");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        wait_drain("t5_drain", 100);
        check("t5_words", 32'(words_o), 32'd1);

        // 6: 400 random bytes, random ready
        idx = 0;
        while (idx < 400) begin
            @(posedge clk_i);
            #1;
            m_ready_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                sb_push(8'($urandom_range(0, 255)));
                idx++;
            end
        end
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b1;
        wait_drain("t6_drain", 3000);
        check("t6_words", 32'(words_o), 32'd101);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
